// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential multiplier and other ALU units.
//   mult_state_t : FSM state of the sequential multiplier (IDLE, CALC, DONE)
//   alu_flags_t  : ALU status flags {neg, zr, cry, of}
//   cnt_width()  : step-counter width for an N-bit multiplier, $clog2(N+1)
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  typedef struct packed {
    logic neg;
    logic zr;
    logic cry;
    logic of;
  } alu_flags_t;

  localparam int unsigned MULT_N_DEF = 4;
  localparam int unsigned MULT_CNT_W = $clog2(MULT_N_DEF + 1);

  // Counter width for an N-step shift-add sequence
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mult_flag_gen.sv
// Combinational ALU flag generation from a 2N-bit product.
// Ports:
//   i_prod        in  2N : full product (two's complement when signed)
//   i_signed_mode in  1  : operation was signed
//   i_mag_cry     in  1  : unsigned magnitude product >= 2^N
//   o_flags_c     out    : {neg, zr, cry, of}, combinational
module mult_flag_gen
  import mult_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [2*N-1:0] i_prod,
  input  logic           i_signed_mode,
  input  logic           i_mag_cry,
  output alu_flags_t     o_flags_c
);

  logic w_sovf;

  // Signed overflow: high half is not the sign extension of the low half
  assign w_sovf = (i_prod[2*N-1:N] != {N{i_prod[N-1]}});

  always_comb begin
    o_flags_c     = '0;
    o_flags_c.neg = i_prod[N-1];
    o_flags_c.zr  = (i_prod[N-1:0] == '0);
    o_flags_c.cry = i_mag_cry;
    o_flags_c.of  = i_signed_mode ? w_sovf : i_mag_cry;
  end

endmodule

// File: rtl/seq_mult_module.sv
// Multi-cycle N x N radix-2 shift-add multiplier with start/done handshake.
// Configuration: define SEQ_MULT_SIGNED_EN to include the signed datapath;
// without it signed_mode is ignored and every operation is unsigned.
// Ports:
//   clk, rst (async, active-high)
//   start, a[N], b[N], signed_mode : request and operands, sampled in IDLE
//   busy       : high while calculating
//   done       : one-cycle pulse when result becomes valid
//   result[N], result_hi[N]         : low / high halves of the product
//   neg_flag, zr_flag, cry_flag, of_flag : flags of last completed op
module seq_mult_module
  import mult_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_mode,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         neg_flag,
  output logic         zr_flag,
  output logic         cry_flag,
  output logic         of_flag
);

  localparam int unsigned PW    = 2 * N;
  localparam int unsigned CNT_W = cnt_width(N);

  mult_state_t      r_state, w_state_nxt;
  logic [PW-1:0]    r_mcand;
  logic [N-1:0]     r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy, r_done;
  logic [N-1:0]     r_result, r_result_hi;
  alu_flags_t       r_flags;

  logic [N-1:0]     w_mag_a, w_mag_b;
  logic [PW-1:0]    w_mag_prod, w_prod;
  logic             w_mag_cry, w_sm;
  alu_flags_t       w_flags;

  // Accumulator value after the current step; on the last step this is the final magnitude
  assign w_mag_prod = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mag_cry  = |w_mag_prod[PW-1:N];

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg, r_sm;

  assign w_mag_a = (signed_mode && a[N-1]) ? (~a + N'(1)) : a;
  assign w_mag_b = (signed_mode && b[N-1]) ? (~b + N'(1)) : b;
  assign w_prod  = r_neg ? (~w_mag_prod + PW'(1)) : w_mag_prod;
  assign w_sm    = r_sm;

  // Sign handling latched with the operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg <= 1'b0;
      r_sm  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_sm  <= signed_mode;
      r_neg <= signed_mode & (a[N-1] ^ b[N-1]);
    end
  end
`else
  logic w_unused_sm;

  assign w_unused_sm = signed_mode;
  assign w_mag_a     = a;
  assign w_mag_b     = b;
  assign w_prod      = w_mag_prod;
  assign w_sm        = 1'b0;
`endif

  mult_flag_gen #(.N(N)) u_flag_gen (
    .i_prod        (w_prod),
    .i_signed_mode (w_sm),
    .i_mag_cry     (w_mag_cry),
    .o_flags_c     (w_flags)
  );

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (r_cnt == CNT_W'(N - 1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, handshake outputs and shift-add datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == CALC);
      r_done  <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{N{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        CALC: begin
          r_acc    <= w_mag_prod;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          // Final step: publish product and flags together with entry to DONE
          if (w_state_nxt == DONE) begin
            r_result    <= w_prod[N-1:0];
            r_result_hi <= w_prod[PW-1:N];
            r_flags     <= w_flags;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign neg_flag  = r_flags.neg;
  assign zr_flag   = r_flags.zr;
  assign cry_flag  = r_flags.cry;
  assign of_flag   = r_flags.of;

endmodule

// File: tb/tb_seq_mult_module.sv
// Scoreboard bench for seq_mult_module (N=4): the driver pushes the expected
// result of each accepted operation, the monitor pops on every done pulse.
module tb_seq_mult_module;

  localparam int unsigned N = 4;

  typedef struct packed {
    logic [N-1:0] res;
    logic [N-1:0] hi;
    logic         neg;
    logic         zr;
    logic         cry;
    logic         of;
  } exp_t;

  logic         clk, rst, start, signed_mode;
  logic [N-1:0] a, b;
  logic         busy, done, neg_flag, zr_flag, cry_flag, of_flag;
  logic [N-1:0] result, result_hi;

  int n_checks = 0;
  int n_errors = 0;
  int n_issued = 0;
  int n_done   = 0;
  exp_t exp_q[$];

  seq_mult_module #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .result_hi   (result_hi),
    .neg_flag    (neg_flag),
    .zr_flag     (zr_flag),
    .cry_flag    (cry_flag),
    .of_flag     (of_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values
  function automatic exp_t model(input int unsigned ua, input int unsigned ub, input bit sm);
    exp_t          e;
    bit            eff;
    longint        sa, sb, p, mag;
    logic [2*N-1:0] pv;
`ifdef SEQ_MULT_SIGNED_EN
    eff = sm;
`else
    eff = sm & 1'b0;
`endif
    if (eff) begin
      sa  = (ua >= (1 << (N - 1))) ? longint'(ua) - (longint'(1) << N) : longint'(ua);
      sb  = (ub >= (1 << (N - 1))) ? longint'(ub) - (longint'(1) << N) : longint'(ub);
      p   = sa * sb;
      mag = (sa < 0 ? -sa : sa) * (sb < 0 ? -sb : sb);
    end else begin
      p   = longint'(ua) * longint'(ub);
      mag = p;
    end
    pv    = (2*N)'(p);
    e.res = pv[N-1:0];
    e.hi  = pv[2*N-1:N];
    e.neg = pv[N-1];
    e.zr  = (pv[N-1:0] == '0);
    e.cry = (mag >= (longint'(1) << N));
    if (eff)
      e.of = (p < -(longint'(1) << (N - 1))) || (p > (longint'(1) << (N - 1)) - 1);
    else
      e.of = e.cry;
    return e;
  endfunction

  // Monitor: compare each done pulse against the oldest expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("result",    result,    e.res);
        check("result_hi", result_hi, e.hi);
        check("neg_flag",  neg_flag,  e.neg);
        check("zr_flag",   zr_flag,   e.zr);
        check("cry_flag",  cry_flag,  e.cry);
        check("of_flag",   of_flag,   e.of);
      end
    end
  end

  // Issue one operation from IDLE and check handshake timing; operands are
  // scrambled after acceptance, and 'poke' re-pulses start while busy.
  task automatic do_op(input int unsigned va, input int unsigned vb, input bit sm, input bit poke);
    @(negedge clk);
    a           = N'(va);
    b           = N'(vb);
    signed_mode = sm;
    start       = 1'b1;
    exp_q.push_back(model(va, vb, sm));
    n_issued++;
    @(posedge clk);
    #1;
    start       = 1'b0;
    a           = N'($urandom);
    b           = N'($urandom);
    signed_mode = 1'($urandom);
    check("busy_t0", busy, 1);
    for (int i = 1; i < int'(N); i++) begin
      @(posedge clk);
      #1;
      check("done_early", done, 0);
      if (poke && i == 1) begin
        start = 1'b1;
        a     = N'(5);
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_tN", done, 1);
    check("busy_tN", busy, 0);
    @(posedge clk);
    #1;
    check("done_pulse_end", done, 0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    a           = '0;
    b           = '0;
    signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   busy,      0);
    check("rst_done",   done,      0);
    check("rst_result", result,    0);
    check("rst_hi",     result_hi, 0);
    check("rst_flags",  {neg_flag, zr_flag, cry_flag, of_flag}, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(3, 4, 1'b0, 1'b0);
    do_op(7, 5, 1'b0, 1'b0);
    do_op(4'b1101, 2, 1'b1, 1'b0);
    do_op(4'b1000, 4'hF, 1'b1, 1'b0);
    do_op(0, 9, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("ignored_start_result", result, 0);
    check("ignored_start_dones", n_done, n_issued);

    do_op(7, 5, 1'b0, 1'b0);

    // Reset two cycles into CALC: outputs clear at once, no done follows
    @(negedge clk);
    a     = 4'd6;
    b     = 4'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy",   busy,      0);
    check("abort_done",   done,      0);
    check("abort_result", result,    0);
    check("abort_hi",     result_hi, 0);
    check("abort_flags",  {neg_flag, zr_flag, cry_flag, of_flag}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", n_done, n_issued);
    do_op(2, 3, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      do_op($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("done_count", n_done, n_issued);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
